i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arbiter.sv | 151 +++++++++++++++
 tb/tb_i2c_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// Purpose : two-client arbiter sharing a single I2C master, round-robin on contention, with a watchdog.
// Latency : grant registered one cycle after a sampled request; master/client data paths are combinational muxes.
// Backpressure: none buffered; clients hold req for the whole transaction, isReady gates arbitration and release.
// Ports   : clk/reset (async active-low); req/gnt per client; start/send/receive/datasend client->master;
//           sended/received/datareceive master->granted client; isReady, m_* master side; busy, tout status.
module i2c_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       start0,
  input  logic       send0,
  input  logic       receive0,
  input  logic       start1,
  input  logic       send1,
  input  logic       receive1,
  input  logic [7:0] datasend0,
  input  logic [7:0] datasend1,
  output logic       sended0,
  output logic       received0,
  output logic       sended1,
  output logic       received1,
  output logic [7:0] datareceive0,
  output logic [7:0] datareceive1,
  input  logic       isReady,
  output logic       m_start,
  output logic       m_send,
  output logic       m_receive,
  output logic [7:0] m_datasend,
  input  logic       m_sended,
  input  logic       m_received,
  input  logic [7:0] m_datareceive,
  output logic       busy,
  output logic       tout
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT0  = 2'b01,
    GRANT1  = 2'b10,
    RELEASE = 2'b11
  } state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        mask0, mask1;
  logic        sended_q, received_q;
  logic [15:0] wd_cnt;

  logic in_grant, expired, activity, eff0, eff1;

  assign in_grant = (state == GRANT0) || (state == GRANT1);
  assign expired  = in_grant && (wd_cnt == TIMEOUT);
  // Any toggle of either master handshake counts as progress.
  assign activity = (m_sended ^ sended_q) | (m_received ^ received_q);
  // A client that timed out is ignored until it drops its request once.
  assign eff0     = req0 & ~mask0;
  assign eff1     = req1 & ~mask1;

  // State register plus the registered side state that follows it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      last_grant <= 1'b1;
      mask0      <= 1'b0;
      mask1      <= 1'b0;
      wd_cnt     <= 16'd0;
      sended_q   <= 1'b0;
      received_q <= 1'b0;
      tout       <= 1'b0;
    end else begin
      state      <= state_nxt;
      // Grants decoded from the next state, so at most one can ever be set.
      gnt0       <= (state_nxt == GRANT0);
      gnt1       <= (state_nxt == GRANT1);
      sended_q   <= m_sended;
      received_q <= m_received;
      tout       <= expired;
      if (state == IDLE && state_nxt == GRANT0) last_grant <= 1'b0;
      if (state == IDLE && state_nxt == GRANT1) last_grant <= 1'b1;
      // Counter sits at zero outside a grant, so every grant starts from zero.
      if (in_grant) wd_cnt <= activity ? 16'd0 : wd_cnt + 16'd1;
      else          wd_cnt <= 16'd0;
      // Setting on expiry wins over clearing, even if req dropped in the same cycle.
      if (expired && state == GRANT0) mask0 <= 1'b1;
      else if (!req0)                 mask0 <= 1'b0;
      if (expired && state == GRANT1) mask1 <= 1'b1;
      else if (!req1)                 mask1 <= 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (isReady && (eff0 || eff1)) begin
          if (eff0 && eff1) state_nxt = last_grant ? GRANT0 : GRANT1;
          else              state_nxt = eff0 ? GRANT0 : GRANT1;
        end
      end
      GRANT0:  if (expired || !req0) state_nxt = RELEASE;
      GRANT1:  if (expired || !req1) state_nxt = RELEASE;
      RELEASE: if (isReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output muxing: only the owning client talks to the master.
  always_comb begin
    m_start      = 1'b0;
    m_send       = 1'b0;
    m_receive    = 1'b0;
    m_datasend   = 8'd0;
    sended0      = 1'b0;
    received0    = 1'b0;
    datareceive0 = 8'd0;
    sended1      = 1'b0;
    received1    = 1'b0;
    datareceive1 = 8'd0;
    busy         = (state != IDLE);
    case (state)
      GRANT0: begin
        m_start      = start0;
        m_send       = send0;
        m_receive    = receive0;
        m_datasend   = datasend0;
        sended0      = m_sended;
        received0    = m_received;
        datareceive0 = m_datareceive;
      end
      GRANT1: begin
        m_start      = start1;
        m_send       = send1;
        m_receive    = receive1;
        m_datasend   = datasend1;
        sended1      = m_sended;
        received1    = m_received;
        datareceive1 = m_datareceive;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Purpose : self-checking bench for i2c_arbiter: vector table, directed corner sequences, random vs model.
// Latency : checks grants one cycle after sampled requests, routing combinationally.
// Backpressure: isReady driven directly by the bench.
module tb_i2c_arbiter;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, start0, send0, receive0, start1, send1, receive1;
  logic [7:0] datasend0, datasend1, m_datareceive;
  logic       isReady, m_sended, m_received;
  logic       gnt0, gnt1, sended0, received0, sended1, received1;
  logic [7:0] datareceive0, datareceive1, m_datasend;
  logic       m_start, m_send, m_receive, busy, tout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i2c_arbiter #(.TIMEOUT(16'd20)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .start0(start0), .send0(send0), .receive0(receive0),
    .start1(start1), .send1(send1), .receive1(receive1),
    .datasend0(datasend0), .datasend1(datasend1),
    .sended0(sended0), .received0(received0),
    .sended1(sended1), .received1(received1),
    .datareceive0(datareceive0), .datareceive1(datareceive1),
    .isReady(isReady), .m_start(m_start), .m_send(m_send), .m_receive(m_receive),
    .m_datasend(m_datasend), .m_sended(m_sended), .m_received(m_received),
    .m_datareceive(m_datareceive), .busy(busy), .tout(tout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [34:0] outvec();
    return {gnt0, gnt1, busy, tout, m_start, m_send, m_receive, m_datasend,
            sended0, received0, sended1, received1, datareceive0, datareceive1};
  endfunction

  task automatic clear_inputs();
    req0 = 0; req1 = 0; start0 = 0; send0 = 0; receive0 = 0;
    start1 = 0; send1 = 0; receive1 = 0; datasend0 = 0; datasend1 = 0;
    isReady = 0; m_sended = 0; m_received = 0; m_datareceive = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    #1 check("reset_outputs", 64'(outvec()), 64'd0);
    cyc();
    cyc();
    check("reset_held", 64'(outvec()), 64'd0);
    reset = 1;
  endtask

  // ---------------- behavioural reference model ----------------
  int owner;     // -1 = nobody owns the master
  int last;
  bit rel;       // waiting for the master to go idle after a transaction
  bit blk [2];
  int wd;        // cycles since last master handshake toggle
  bit ps, pr, tout_e;

  task automatic model_init();
    owner = -1; last = 1; rel = 0; blk[0] = 0; blk[1] = 0;
    wd = 0; ps = 0; pr = 0; tout_e = 0;
  endtask

  function automatic logic [34:0] model_out();
    logic g0, g1, ms, msd, mr;
    logic [7:0] mds, dr0, dr1;
    logic s0, r0, s1, r1;
    g0 = (owner == 0); g1 = (owner == 1);
    ms = 0; msd = 0; mr = 0; mds = 0; s0 = 0; r0 = 0; s1 = 0; r1 = 0; dr0 = 0; dr1 = 0;
    if (g0) begin
      ms = start0; msd = send0; mr = receive0; mds = datasend0;
      s0 = m_sended; r0 = m_received; dr0 = m_datareceive;
    end
    if (g1) begin
      ms = start1; msd = send1; mr = receive1; mds = datasend1;
      s1 = m_sended; r1 = m_received; dr1 = m_datareceive;
    end
    return {g0, g1, (owner >= 0) || rel, tout_e, ms, msd, mr, mds, s0, r0, s1, r1, dr0, dr1};
  endfunction

  task automatic model_step();
    bit rq [2];
    bit act, c0, c1;
    int setm;
    rq[0] = req0; rq[1] = req1;
    act = (m_sended != ps) || (m_received != pr);
    setm = -1;
    tout_e = 0;
    if (owner >= 0) begin
      if (wd == TO) begin
        tout_e = 1; setm = owner; owner = -1; rel = 1;
      end else if (!rq[owner]) begin
        owner = -1; rel = 1;
      end else begin
        wd = act ? 0 : wd + 1;
      end
    end else if (rel) begin
      if (isReady) rel = 0;
    end else if (isReady) begin
      c0 = rq[0] && !blk[0];
      c1 = rq[1] && !blk[1];
      if (c0 && c1)  owner = 1 - last;
      else if (c0)   owner = 0;
      else if (c1)   owner = 1;
      if (owner >= 0) begin
        last = owner; wd = 0;
      end
    end
    for (int n = 0; n < 2; n++) if (!rq[n]) blk[n] = 0;
    if (setm >= 0) blk[setm] = 1;
    ps = m_sended; pr = m_received;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic r0, r1, rdy;
    logic g0, g1, b;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [31:0] r;
    int lvl;

    tbl[0]  = 6'b100_000;  // not ready: no arbitration
    tbl[1]  = 6'b111_101;  // contest after reset: client 0 wins
    tbl[2]  = 6'b111_101;
    tbl[3]  = 6'b011_001;  // req0 drops -> release
    tbl[4]  = 6'b011_000;  // master idle -> IDLE
    tbl[5]  = 6'b011_011;  // client 1 granted
    tbl[6]  = 6'b001_001;
    tbl[7]  = 6'b111_000;  // requests ignored while leaving release
    tbl[8]  = 6'b111_101;  // round-robin back to client 0
    tbl[9]  = 6'b010_001;
    tbl[10] = 6'b010_001;  // release held while master busy
    tbl[11] = 6'b011_000;
    tbl[12] = 6'b010_000;  // idle but master not ready
    tbl[13] = 6'b011_011;
    tbl[14] = 6'b000_001;

    reset = 0;
    clear_inputs();
    do_reset();

    for (int i = 0; i < 15; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1; isReady = tbl[i].rdy;
      cyc();
      check($sformatf("table_%0d", i), 64'({gnt0, gnt1, busy}),
            64'({tbl[i].g0, tbl[i].g1, tbl[i].b}));
    end

    // Release held for 10 cycles while the master stays busy.
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("release_hold", 64'({gnt0, gnt1, busy}), 64'(3'b001));
    end
    isReady = 1;
    cyc();
    check("release_exit", 64'({gnt0, gnt1, busy}), 64'(3'b000));

    // Routing to the granted client only.
    do_reset();
    req0 = 1; isReady = 1; datasend0 = 8'hEE; start0 = 1; datasend1 = 8'h33; start1 = 1;
    #1 check("idle_mux", 64'({m_start, m_datasend}), 64'd0);
    cyc();
    check("gnt0_latency", 64'({gnt0, gnt1}), 64'(2'b10));
    check("m_datasend", 64'({m_start, m_datasend}), 64'({1'b1, 8'hEE}));
    m_sended = 1; m_datareceive = 8'h5A;
    #1 check("sended_route", 64'({sended0, sended1}), 64'(2'b10));
    check("rx_route", 64'({datareceive0, datareceive1}), 64'({8'h5A, 8'h00}));
    req0 = 0;
    cyc();
    cyc();

    // Watchdog expiry with no master activity.
    do_reset();
    req0 = 1; isReady = 1;
    cyc();
    check("wd_grant", 64'(gnt0), 64'd1);
    for (int k = 1; k <= 21; k++) begin
      cyc();
      if (k < 21) check("wd_count", 64'({gnt0, tout}), 64'(2'b10));
      else        check("wd_expire", 64'({gnt0, tout}), 64'(2'b01));
    end
    cyc();
    check("tout_pulse", 64'(tout), 64'd0);
    for (int k = 0; k < 30; k++) begin
      cyc();
      check("masked_req", 64'(gnt0), 64'd0);
    end
    req0 = 0;
    cyc();
    req0 = 1;
    cyc();
    check("unmask_regrant", 64'(gnt0), 64'd1);

    // Periodic master activity keeps the watchdog quiet.
    for (int c = 1; c <= 100; c++) begin
      if (c % 15 == 0) m_sended = ~m_sended;
      cyc();
      check("wd_kept_alive", 64'({gnt0, tout}), 64'(2'b10));
    end
    req0 = 0;
    cyc();
    cyc();

    // Asynchronous reset during a client 1 transaction.
    do_reset();
    req1 = 1; isReady = 1; receive1 = 1;
    cyc();
    check("gnt1_active", 64'({gnt1, m_receive, busy}), 64'(3'b111));
    req0 = 1;
    @(posedge clk);
    #3 reset = 0;
    #1 check("async_reset", 64'({gnt0, gnt1, m_receive, busy}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset_no_grant", 64'({gnt0, gnt1}), 64'd0);
    reset = 1;
    cyc();
    check("post_reset_gnt0", 64'({gnt0, gnt1}), 64'(2'b10));

    // Random stimulus against the reference model.
    do_reset();
    model_init();
    for (int i = 0; i < 2500; i++) begin
      lvl = (i < 1200) ? 6 : 40;
      if ($urandom_range(7) == 0) req0 = ~req0;
      if ($urandom_range(7) == 0) req1 = ~req1;
      isReady = ($urandom_range(3) != 0);
      r = $urandom;
      start0 = r[0]; send0 = r[1]; receive0 = r[2];
      start1 = r[3]; send1 = r[4]; receive1 = r[5];
      datasend0 = r[15:8]; datasend1 = r[23:16]; m_datareceive = r[31:24];
      if ($urandom_range(lvl - 1) == 0) m_sended = ~m_sended;
      if ($urandom_range(lvl + 3) == 0) m_received = ~m_received;
      #1 check("random", 64'(outvec()), 64'(model_out()));
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
